instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 199 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: turns RV32I instruction requests into 32-bit words and
// streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int MEM_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      base_load_i,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                op_i,
    input  logic [2:0]                funct3_i,
    input  logic                      alt_i,
    input  logic [4:0]                rd_i,
    input  logic [4:0]                rs1_i,
    input  logic [4:0]                rs2_i,
    input  logic [31:0]               imm_i,
    output logic                      mem_w_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_data_o,
    output logic [3:0]                write_transfer_o,
    input  logic                      mem_ready_i,
    output logic                      err_o,
    output logic [15:0]               count_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    state_t                    state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]               data_q, data_d;
    logic [15:0]               count_q, count_d;
    logic                      err_q, err_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        accept;

    // Immediate range predicates: the value fits when all bits above the
    // signed field are copies of its sign bit.
    logic imm_fits_12, imm_fits_13, imm_fits_21, imm_is_shamt;
    assign imm_fits_12  = (imm_i[31:11] == {21{imm_i[11]}});
    assign imm_fits_13  = (imm_i[31:12] == {20{imm_i[12]}});
    assign imm_fits_21  = (imm_i[31:20] == {12{imm_i[20]}});
    assign imm_is_shamt = (imm_i[31:5] == 27'd0);

    // Build the instruction word for the presented request and judge legality.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        enc_word  = 32'd0;
        enc_legal = 1'b1;
        case (op_i)
            4'd0: begin
                enc_word = {imm_i[31:12], rd_i, OPC_LUI};
                if (imm_i[11:0] != 12'd0) enc_legal = 1'b0;
            end
            4'd1: begin
                enc_word = {imm_i[31:12], rd_i, OPC_AUIPC};
                if (imm_i[11:0] != 12'd0) enc_legal = 1'b0;
            end
            4'd2: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                if (!imm_fits_21 || imm_i[0]) enc_legal = 1'b0;
            end
            4'd3: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_JALR};
                if (!imm_fits_12 || funct3_i != 3'b000) enc_legal = 1'b0;
            end
            4'd4: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], OPC_BRANCH};
                if (!imm_fits_13 || imm_i[0] || funct3_i == 3'b010 || funct3_i == 3'b011)
                    enc_legal = 1'b0;
            end
            4'd5: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                if (!imm_fits_12 || funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)
                    enc_legal = 1'b0;
            end
            4'd6: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
                if (!imm_fits_12 || funct3_i > 3'b010) enc_legal = 1'b0;
            end
            4'd7: begin
                if (funct3_i[1:0] == 2'b01) begin
                    // Shifts carry a 5-bit shamt with alt_i selecting SRAI.
                    enc_word = {1'b0, alt_i, 5'b0, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    if (!imm_is_shamt) enc_legal = 1'b0;
                end else begin
                    enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
                    if (!imm_fits_12) enc_legal = 1'b0;
                end
            end
            4'd8: begin
                enc_word = {1'b0, alt_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
            end
            4'd9: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_FENCE};
            end
            4'd10: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_SYSTEM};
                if (!imm_fits_12) enc_legal = 1'b0;
            end
            default: enc_legal = 1'b0;
        endcase
        // alt_i is only meaningful for SUB, SRA and SRAI.
        if (alt_i && !((op_i == 4'd8 && (funct3_i == 3'b000 || funct3_i == 3'b101)) ||
                       (op_i == 4'd7 && funct3_i == 3'b101)))
            enc_legal = 1'b0;
    end

    assign req_ready_o = (state_q == S_IDLE) ? 1'b1 : mem_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    // Next-state logic: base loading, request acceptance and write retirement.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (base_load_i) begin
                    addr_d  = base_addr_i;
                    count_d = 16'd0;
                end
                if (accept) begin
                    if (enc_legal) begin
                        data_d  = enc_word;
                        state_d = S_WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready_i) begin
                    addr_d  = addr_q + MEM_ADDR_WIDTH'(4);
                    count_d = count_q + 16'd1;
                    state_d = S_IDLE;
                    if (accept) begin
                        if (enc_legal) begin
                            data_d  = enc_word;
                            state_d = S_WRITE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= 32'd0;
            count_q <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign mem_w_o          = (state_q == S_WRITE);
    assign mem_addr_o       = addr_q;
    assign mem_data_o       = data_q;
    assign write_transfer_o = mem_w_o ? 4'b1111 : 4'b0000;
    assign err_o            = err_q;
    assign count_o          = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        base_load_i;
    logic [31:0] base_addr_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  op_i;
    logic [2:0]  funct3_i;
    logic        alt_i;
    logic [4:0]  rd_i, rs1_i, rs2_i;
    logic [31:0] imm_i;
    logic        mem_w_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [3:0]  write_transfer_o;
    logic        mem_ready_i;
    logic        err_o;
    logic [15:0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    instr_encoder #(.MEM_ADDR_WIDTH(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .base_load_i      (base_load_i),
        .base_addr_i      (base_addr_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .op_i             (op_i),
        .funct3_i         (funct3_i),
        .alt_i            (alt_i),
        .rd_i             (rd_i),
        .rs1_i            (rs1_i),
        .rs2_i            (rs2_i),
        .imm_i            (imm_i),
        .mem_w_o          (mem_w_o),
        .mem_addr_o       (mem_addr_o),
        .mem_data_o       (mem_data_o),
        .write_transfer_o (write_transfer_o),
        .mem_ready_i      (mem_ready_i),
        .err_o            (err_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [2:0]  f3;
        logic        alt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; sample and drive 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        op_i = op; funct3_i = f3; alt_i = alt;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        req_valid_i = 1'b1;
    endtask

    logic [31:0] exp_addr;
    logic [15:0] exp_count;

    initial begin
        // name, op, f3, alt, rd, rs1, rs2, imm, legal, word
        vecs[0]  = '{"jal_2048",     4'd2,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_0800, 1'b1, 32'h001000EF};
        vecs[1]  = '{"sw_8",         4'd6,  3'd2, 1'b0, 5'd0,  5'd2, 5'd5, 32'h0000_0008, 1'b1, 32'h00512423};
        vecs[2]  = '{"lw_m4",        4'd5,  3'd2, 1'b0, 5'd3,  5'd1, 5'd0, 32'hFFFF_FFFC, 1'b1, 32'hFFC0A183};
        vecs[3]  = '{"srai_3",       4'd7,  3'd5, 1'b1, 5'd4,  5'd4, 5'd0, 32'h0000_0003, 1'b1, 32'h40325213};
        vecs[4]  = '{"jalr_ret",     4'd3,  3'd0, 1'b0, 5'd0,  5'd1, 5'd0, 32'h0000_0000, 1'b1, 32'h00008067};
        vecs[5]  = '{"auipc",        4'd1,  3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0000_1000, 1'b1, 32'h00001517};
        vecs[6]  = '{"ecall",        4'd10, 3'd0, 1'b0, 5'd0,  5'd0, 5'd0, 32'h0000_0000, 1'b1, 32'h00000073};
        vecs[7]  = '{"add",          4'd8,  3'd0, 1'b0, 5'd1,  5'd2, 5'd3, 32'h0000_0000, 1'b1, 32'h003100B3};
        vecs[8]  = '{"addi_2047",    4'd7,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_07FF, 1'b1, 32'h7FF00093};
        vecs[9]  = '{"bne_4094",     4'd4,  3'd1, 1'b0, 5'd0,  5'd0, 5'd0, 32'h0000_0FFE, 1'b1, 32'h7E001FE3};
        vecs[10] = '{"beq_odd",      4'd4,  3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'h0000_0003, 1'b0, 32'h0};
        vecs[11] = '{"slli_32",      4'd7,  3'd1, 1'b0, 5'd1,  5'd1, 5'd0, 32'h0000_0020, 1'b0, 32'h0};
        vecs[12] = '{"op_11",        4'd11, 3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[13] = '{"lui_lowbits",  4'd0,  3'd0, 1'b0, 5'd5,  5'd0, 5'd0, 32'h1234_5001, 1'b0, 32'h0};
        vecs[14] = '{"jal_odd",      4'd2,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_0001, 1'b0, 32'h0};
        vecs[15] = '{"jal_range",    4'd2,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0010_0000, 1'b0, 32'h0};
        vecs[16] = '{"br_f3_010",    4'd4,  3'd2, 1'b0, 5'd0,  5'd1, 5'd2, 32'h0000_0008, 1'b0, 32'h0};
        vecs[17] = '{"addi_2048",    4'd7,  3'd0, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_0800, 1'b0, 32'h0};
        vecs[18] = '{"lw_f3_011",    4'd5,  3'd3, 1'b0, 5'd1,  5'd0, 5'd0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[19] = '{"sw_f3_011",    4'd6,  3'd3, 1'b0, 5'd0,  5'd1, 5'd2, 32'h0000_0000, 1'b0, 32'h0};
        vecs[20] = '{"jalr_f3_001",  4'd3,  3'd1, 1'b0, 5'd1,  5'd1, 5'd0, 32'h0000_0000, 1'b0, 32'h0};
        vecs[21] = '{"addi_alt",     4'd7,  3'd0, 1'b1, 5'd1,  5'd0, 5'd0, 32'h0000_0001, 1'b0, 32'h0};
        vecs[22] = '{"sll_alt",      4'd8,  3'd1, 1'b1, 5'd1,  5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h0};
        vecs[23] = '{"br_4096",      4'd4,  3'd0, 1'b0, 5'd0,  5'd1, 5'd2, 32'h0000_1000, 1'b0, 32'h0};

        rst = 1'b1; base_load_i = 1'b0; base_addr_i = 32'd0; req_valid_i = 1'b0;
        op_i = 4'd0; funct3_i = 3'd0; alt_i = 1'b0; rd_i = 5'd0; rs1_i = 5'd0;
        rs2_i = 5'd0; imm_i = 32'd0; mem_ready_i = 1'b0;
        step();
        step();

        // Reset state.
        check("rst_mem_w",  {31'd0, mem_w_o}, 32'd0);
        check("rst_addr",   mem_addr_o, 32'd0);
        check("rst_data",   mem_data_o, 32'd0);
        check("rst_count",  {16'd0, count_o}, 32'd0);
        check("rst_err",    {31'd0, err_o}, 32'd0);
        check("rst_strobe", {28'd0, write_transfer_o}, 32'd0);
        check("rst_ready",  {31'd0, req_ready_o}, 32'd1);
        rst = 1'b0;

        // Base load 0x100 together with addi x1,x0,5 on the same edge.
        base_load_i = 1'b1; base_addr_i = 32'h100;
        set_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        base_load_i = 1'b0; req_valid_i = 1'b0;
        check("addi_mem_w",  {31'd0, mem_w_o}, 32'd1);
        check("addi_data",   mem_data_o, 32'h00500093);
        check("addi_addr",   mem_addr_o, 32'h100);
        check("addi_strobe", {28'd0, write_transfer_o}, 32'hF);
        check("addi_count",  {16'd0, count_o}, 32'd0);

        // Stall five cycles; a base load and a request are both presented and
        // must be ignored.
        base_load_i = 1'b1; base_addr_i = 32'h999;
        set_req(4'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_mem_w", {31'd0, mem_w_o}, 32'd1);
            check("stall_data",  mem_data_o, 32'h00500093);
            check("stall_addr",  mem_addr_o, 32'h100);
            check("stall_ready", {31'd0, req_ready_o}, 32'd0);
        end
        base_load_i = 1'b0; req_valid_i = 1'b0; mem_ready_i = 1'b1;
        step();
        check("release_mem_w", {31'd0, mem_w_o}, 32'd0);
        check("release_addr",  mem_addr_o, 32'h104);
        check("release_count", {16'd0, count_o}, 32'd1);

        // Back-to-back stream: lui, sub, beq at 0x100/0x104/0x108.
        base_load_i = 1'b1; base_addr_i = 32'h100;
        step();
        base_load_i = 1'b0;
        check("rebase_addr",  mem_addr_o, 32'h100);
        check("rebase_count", {16'd0, count_o}, 32'd0);
        set_req(4'd0, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        step();
        check("lui_data", mem_data_o, 32'h123452B7);
        check("lui_addr", mem_addr_o, 32'h100);
        set_req(4'd8, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        check("b2b_ready", {31'd0, req_ready_o}, 32'd1);
        step();
        check("sub_data",  mem_data_o, 32'h402081B3);
        check("sub_addr",  mem_addr_o, 32'h104);
        check("sub_count", {16'd0, count_o}, 32'd1);
        check("sub_mem_w", {31'd0, mem_w_o}, 32'd1);
        set_req(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        step();
        check("beq_data",  mem_data_o, 32'hFE208CE3);
        check("beq_addr",  mem_addr_o, 32'h108);
        check("beq_count", {16'd0, count_o}, 32'd2);
        req_valid_i = 1'b0;
        step();
        check("stream_idle",  {31'd0, mem_w_o}, 32'd0);
        check("stream_addr",  mem_addr_o, 32'h10C);
        check("stream_count", {16'd0, count_o}, 32'd3);
        exp_addr  = 32'h10C;
        exp_count = 16'd3;

        // Table of single requests, legal and illegal.
        for (int i = 0; i < NV; i++) begin
            set_req(vecs[i].op, vecs[i].f3, vecs[i].alt, vecs[i].rd,
                    vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            step();
            req_valid_i = 1'b0;
            if (vecs[i].legal) begin
                check({vecs[i].name, "_mem_w"}, {31'd0, mem_w_o}, 32'd1);
                check({vecs[i].name, "_data"},  mem_data_o, vecs[i].word);
                check({vecs[i].name, "_err"},   {31'd0, err_o}, 32'd0);
            end else begin
                check({vecs[i].name, "_err"},   {31'd0, err_o}, 32'd1);
                check({vecs[i].name, "_mem_w"}, {31'd0, mem_w_o}, 32'd0);
            end
            step();
            if (vecs[i].legal) begin
                exp_addr  = exp_addr + 32'd4;
                exp_count = exp_count + 16'd1;
            end
            check({vecs[i].name, "_err_end"},   {31'd0, err_o}, 32'd0);
            check({vecs[i].name, "_idle"},      {31'd0, mem_w_o}, 32'd0);
            check({vecs[i].name, "_addr_end"},  mem_addr_o, exp_addr);
            check({vecs[i].name, "_count_end"}, {16'd0, count_o}, {16'd0, exp_count});
        end

        // Address wrap at the top of the address space.
        base_load_i = 1'b1; base_addr_i = 32'hFFFF_FFFC;
        set_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        base_load_i = 1'b0; req_valid_i = 1'b0;
        check("wrap_addr_pre", mem_addr_o, 32'hFFFF_FFFC);
        check("wrap_mem_w",    {31'd0, mem_w_o}, 32'd1);
        step();
        check("wrap_addr",  mem_addr_o, 32'h0000_0000);
        check("wrap_count", {16'd0, count_o}, 32'd1);

        // Reset in the middle of a stalled write abandons it.
        mem_ready_i = 1'b0;
        set_req(4'd7, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        step();
        req_valid_i = 1'b0;
        check("midrst_pre_w", {31'd0, mem_w_o}, 32'd1);
        rst = 1'b1;
        step();
        check("midrst_mem_w", {31'd0, mem_w_o}, 32'd0);
        check("midrst_addr",  mem_addr_o, 32'd0);
        check("midrst_count", {16'd0, count_o}, 32'd0);
        check("midrst_ready", {31'd0, req_ready_o}, 32'd1);
        rst = 1'b0; mem_ready_i = 1'b1;
        step();
        check("midrst_post_w",     {31'd0, mem_w_o}, 32'd0);
        check("midrst_post_count", {16'd0, count_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
